// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its user / circuit under test.
//   start              : request a run
//   Q                  : output of the circuit under test
//   A,B,C              : stimulus to the circuit under test ({A,B,C} = index)
//   busy/done/pass     : run status
//   response           : captured Q per index
//   fail_valid/_index  : lowest mismatching index after a run
// master = user side (drives start and Q), slave = sequencer.
interface truth_table_sequencer_if;
  logic       start;
  logic       Q;
  logic       A, B, C;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] response;
  logic       fail_valid;
  logic [2:0] fail_index;

  modport master (
    output start, Q,
    input  A, B, C, busy, done, pass, response, fail_valid, fail_index
  );
  modport slave (
    input  start, Q,
    output A, B, C, busy, done, pass, response, fail_valid, fail_index
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Stimulus generator / response checker for a 3-input, 1-output registered
// circuit. Walks {A,B,C} through 000..111, holds each combination for
// HOLD_CYCLES cycles, then captures Q for one cycle. After index 7, the
// response is compared against EXPECTED.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of truth_table_sequencer_if
module truth_table_sequencer #(
  parameter int         HOLD_CYCLES = 1,   // 1..15
  parameter logic [7:0] EXPECTED    = 8'hE8
) (
  input logic                    clk,
  input logic                    reset,
  truth_table_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] idx;
  logic [3:0] hcnt;
  logic [7:0] resp;
  logic       pass_r, fv_r;
  logic [2:0] fi_r;

  logic       start_run;
  logic       hold_end;
  logic [7:0] resp_nx;   // response including the bit being captured now
  logic [7:0] mism;
  logic [2:0] first_bad;

  // start is only honoured when no run is in progress.
  assign start_run = ((state == IDLE) || (state == DONE)) && bus.start;
  assign hold_end  = (hcnt == 4'(HOLD_CYCLES - 1));

  always_comb begin
    resp_nx      = resp;
    resp_nx[idx] = bus.Q;
    mism         = resp_nx ^ EXPECTED;
    first_bad    = 3'd0;
    // Scan downward so the lowest mismatching index wins.
    for (int i = 7; i >= 0; i--)
      if (mism[i]) first_bad = 3'(i);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_run) state_nx = APPLY;
      APPLY:   if (hold_end) state_nx = CAPTURE;
      CAPTURE: state_nx = (idx == 3'd7) ? DONE : APPLY;
      DONE:    if (start_run) state_nx = APPLY;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      hcnt   <= '0;
      resp   <= '0;
      pass_r <= 1'b0;
      fv_r   <= 1'b0;
      fi_r   <= '0;
    end else if (start_run) begin
      idx    <= '0;
      hcnt   <= '0;
      resp   <= '0;
      pass_r <= 1'b0;
      fv_r   <= 1'b0;
      fi_r   <= '0;
    end else begin
      case (state)
        APPLY: hcnt <= hcnt + 4'd1;
        CAPTURE: begin
          resp <= resp_nx;
          if (idx == 3'd7) begin
            // Verdict uses resp_nx so the bit captured on this edge counts.
            pass_r <= (mism == 8'd0);
            fv_r   <= |mism;
            fi_r   <= first_bad;
          end else begin
            idx  <= idx + 3'd1;
            hcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign {bus.A, bus.B, bus.C} = idx;
  assign bus.busy       = (state == APPLY) || (state == CAPTURE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass_r;
  assign bus.response   = resp;
  assign bus.fail_valid = fv_r;
  assign bus.fail_index = fi_r;

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Synthesizable stimulus generator and response checker for a 3-input, 1-output registered circuit under test. It drives the three inputs through all eight combinations 000→111 in order and holds each combination for a programmable number of cycles. It samples the circuit's `Q` once per combination into an 8-bit response word and compares the result against an expected truth table. It sits next to the circuit under test in lab top-levels so the circuit can be self-checked in hardware without a simulation bench.

## Interface
- `HOLD_CYCLES`, default 1: cycles each input combination is applied before capture; legal range 1–15.
- `EXPECTED`, default 8'hE8: expected response word; bit i is the expected `Q` for input index i = {A,B,C}. The default is 3-input majority.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a run; sampled only in IDLE or DONE.
- `Q` input 1: output of the circuit under test.
- `A` output 1: MSB of the current input index; registered.
- `B` output 1: middle bit of the current input index; registered.
- `C` output 1: LSB of the current input index; registered.
- `busy` output 1: high while a run is in progress (APPLY or CAPTURE).
- `done` output 1: high in DONE; stays high until the next run starts or reset.
- `pass` output 1: 1 when the final response equals `EXPECTED`; valid while `done` is high, 0 otherwise.
- `response` output 8: captured `Q` values; bit i corresponds to index i.
- `fail_valid` output 1: 1 when `done` is high and at least one bit mismatches.
- `fail_index` output 3: lowest index whose bit mismatches; 0 when `fail_valid` is 0.

## Operation
- State machine states: IDLE, APPLY, CAPTURE, DONE.
- Registers: 3-bit index `idx`; 4-bit hold counter `hcnt`; 8-bit `response`.
- `{A,B,C}` always equals `idx`, so the inputs stay stable for the whole APPLY+CAPTURE window of each index.
- IDLE, `start`=1 → APPLY:
  - `idx`=0, `hcnt`=0, `response` cleared to 0.
- APPLY:
  - `hcnt` increments each cycle.
  - When `hcnt` = `HOLD_CYCLES`-1 → CAPTURE.
- CAPTURE, lasting 1 cycle:
  - On the edge ending this cycle, `response[idx]` ← `Q`.
  - If `idx`=7 → DONE.
  - Otherwise `idx` increments, `hcnt`=0, → APPLY.
- DONE:
  - `pass`, `fail_valid` and `fail_index` are computed from the final response, including the bit written on the entering edge.
  - They are registered and held.
  - `start`=1 → APPLY, with the same clearing as from IDLE.
- `start` is ignored in APPLY and CAPTURE; holding it high has no effect on a run in progress.
- `idx` never wraps during a run; 7 is terminal.
- Reset, asynchronous and taking effect at any time including mid-run:
  - State ← IDLE.
  - `A`,`B`,`C`,`busy`,`done`,`pass`,`fail_valid` = 0; `fail_index` = 0; `response` = 0.
  - No partial result is retained.

## Timing
- The circuit under test is assumed registered with one cycle of latency. Because `HOLD_CYCLES` ≥ 1, `Q` reflects the current index by the CAPTURE cycle.
- Let edge E0 be the edge that samples `start`.
  - `busy`=1 and `{A,B,C}`=000 from the cycle after E0.
  - Each index occupies `HOLD_CYCLES`+1 cycles.
  - The run lasts 8×(`HOLD_CYCLES`+1) cycles.
  - `done`=1 in the cycle immediately after the final CAPTURE; `busy` drops in that same cycle.
- `pass`, `fail_valid` and `fail_index` become valid in the same cycle as `done`.
- On restart from DONE, `done`, `pass`, `fail_valid` and `response` clear in the first APPLY cycle.

## Test plan
- **Reset:** assert `reset` with `start` high → all outputs 0, `busy`=0, and no run begins while `reset` is high.
- **Good circuit** (`HOLD_CYCLES`=1, `Q` from a registered majority model): pulse `start` →
  - `{A,B,C}` steps 000,000,001,001,…,111,111.
  - `done`=1 exactly 17 cycles after E0.
  - `response`=8'hE8, `pass`=1, `fail_valid`=0.
- **Stuck-at-0 circuit** (`Q` tied 0) → `response`=8'h00, `pass`=0, `fail_valid`=1, `fail_index`=3.
- **`start` handling:** hold `start` high through a whole run → a single run only, DONE reached on schedule. A later `start` pulse in DONE → a new run, with `response` and `done` cleared in its first cycle.
- **Reset mid-run:** assert `reset` while `{A,B,C}`=100 → all outputs 0 immediately, state IDLE. A new `start` runs from 000 with full timing.
- **`HOLD_CYCLES`=3:** each index is held 4 cycles, `done` is asserted 33 cycles after E0, and `response` is correct for the majority model.
